// File: rtl/uart_fifo.sv
// uart_fifo: buffered asynchronous UART with a 16x oversampling baud generator,
// configurable character width, optional parity, 1 or 2 stop bits, and
// power-of-two TX/RX FIFOs whose entries carry per-character error tags.
//
// Ports:
//   clk, rst_n                   system clock, asynchronous active-low reset
//   UART_TXD / UART_RXD          serial out (registered, idles high) / serial in (async)
//   baud_div                     16x tick every baud_div+1 clocks
//   parity_en, parity_odd, stop2 frame format
//   tx_en, rx_en                 transmitter / receiver enable
//   tx_data, tx_wr_en            TX FIFO push
//   tx_full, tx_empty, tx_busy, tx_level   TX status
//   rx_data, rx_ferr, rx_perr    RX FIFO head entry (zero when empty)
//   rx_rd_en                     RX FIFO pop
//   rx_valid, rx_full, rx_level  RX status
//   rx_oerr, oerr_clr            sticky overrun flag and its clear
module uart_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned TX_DEPTH  = 4,
  parameter int unsigned RX_DEPTH  = 4,
  parameter int unsigned DIV_WIDTH = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic                            UART_TXD,
  input  logic                            UART_RXD,
  input  logic [DIV_WIDTH-1:0]            baud_div,
  input  logic                            parity_en,
  input  logic                            parity_odd,
  input  logic                            stop2,
  input  logic                            tx_en,
  input  logic                            rx_en,
  input  logic [DATA_BITS-1:0]            tx_data,
  input  logic                            tx_wr_en,
  output logic                            tx_full,
  output logic                            tx_empty,
  output logic                            tx_busy,
  output logic [$clog2(TX_DEPTH+1)-1:0]   tx_level,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_ferr,
  output logic                            rx_perr,
  input  logic                            rx_rd_en,
  output logic                            rx_valid,
  output logic                            rx_full,
  output logic [$clog2(RX_DEPTH+1)-1:0]   rx_level,
  output logic                            rx_oerr,
  input  logic                            oerr_clr
);
  localparam int unsigned TXA = $clog2(TX_DEPTH);
  localparam int unsigned RXA = $clog2(RX_DEPTH);
  localparam int unsigned TXL = $clog2(TX_DEPTH + 1);
  localparam int unsigned RXL = $clog2(RX_DEPTH + 1);
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- baud generator ----------------
  logic [DIV_WIDTH-1:0] bcnt;
  logic                 tick;
  assign tick = (bcnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    bcnt <= '0;
    else if (tick) bcnt <= baud_div;
    else           bcnt <= bcnt - DIV_WIDTH'(1);
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TXA-1:0]       tx_wp, tx_rp;
  logic [TXL-1:0]       tx_cnt;
  logic                 tx_pop, tx_push;

  assign tx_full  = (tx_cnt == TXL'(TX_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_level = tx_cnt;
  assign tx_push  = tx_wr_en && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TXA'(1);
      if (tx_pop)  tx_rp <= tx_rp + TXA'(1);
      tx_cnt <= tx_cnt + TXL'(tx_push) - TXL'(tx_pop);
    end
  end

  // ---------------- TX FSM ----------------
  state_t               tx_state, tx_nstate;
  logic [4:0]           tx_tcnt, tx_last;
  logic [3:0]           tx_bcnt;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_nxt;
  logic                 tx_pen, tx_pbit, tx_s2, txd_nxt, tx_bit_end;

  // Only the stop phase can stretch to 32 ticks; every other bit is 16.
  assign tx_last    = (tx_state == S_STOP && tx_s2) ? 5'd31 : 5'd15;
  assign tx_bit_end = tick && (tx_tcnt == tx_last);
  assign tx_busy    = (tx_state != S_IDLE);

  always_comb begin
    tx_nstate = tx_state;
    tx_pop    = 1'b0;
    tx_sh_nxt = tx_sh;
    txd_nxt   = 1'b1;
    case (tx_state)
      S_IDLE:
        if (tick && tx_en && !tx_empty) begin
          tx_pop    = 1'b1;
          tx_nstate = S_START;
          tx_sh_nxt = tx_mem[tx_rp];
        end
      S_START:  if (tx_bit_end) tx_nstate = S_DATA;
      S_DATA:
        if (tx_bit_end) begin
          if (tx_bcnt == LAST_BIT) tx_nstate = tx_pen ? S_PARITY : S_STOP;
          else                     tx_sh_nxt = tx_sh >> 1;
        end
      S_PARITY: if (tx_bit_end) tx_nstate = S_STOP;
      S_STOP:   if (tx_bit_end) tx_nstate = S_IDLE;
      default:  tx_nstate = S_IDLE;
    endcase
    // Line value follows the state being entered so UART_TXD stays a flop.
    case (tx_nstate)
      S_START:  txd_nxt = 1'b0;
      S_DATA:   txd_nxt = tx_sh_nxt[0];
      S_PARITY: txd_nxt = tx_pbit;
      default:  txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      UART_TXD <= 1'b1;
      tx_sh    <= '0;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_pen   <= 1'b0;
      tx_pbit  <= 1'b0;
      tx_s2    <= 1'b0;
    end else begin
      tx_state <= tx_nstate;
      UART_TXD <= txd_nxt;
      tx_sh    <= tx_sh_nxt;
      if (tx_pop) begin
        tx_pen  <= parity_en;
        tx_pbit <= (^tx_mem[tx_rp]) ^ parity_odd;
        tx_s2   <= stop2;
        tx_tcnt <= '0;
        tx_bcnt <= '0;
      end else if (tx_bit_end) begin
        tx_tcnt <= '0;
        if (tx_state == S_DATA) tx_bcnt <= tx_bcnt + 4'd1;
      end else if (tick && tx_state != S_IDLE) begin
        tx_tcnt <= tx_tcnt + 5'd1;
      end
    end
  end

  // ---------------- RX synchroniser and FSM ----------------
  logic [1:0]           rx_sync;
  logic                 rxs;
  state_t               rx_state, rx_nstate;
  logic [3:0]           rx_tcnt, rx_bcnt;
  logic [2:0]           rx_smp;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_perr_r, maj, rx_decide, rx_bit_end, rx_push;
  logic [DATA_BITS+1:0] rx_word;

  assign rxs        = rx_sync[1];
  assign maj        = (rx_smp[0] & rx_smp[1]) | (rx_smp[0] & rx_smp[2]) | (rx_smp[1] & rx_smp[2]);
  assign rx_decide  = tick && (rx_tcnt == 4'd10);
  assign rx_bit_end = tick && (rx_tcnt == 4'd15);
  assign rx_word    = {rx_perr_r, ~maj, rx_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], UART_RXD};
  end

  always_comb begin
    rx_nstate = rx_state;
    rx_push   = 1'b0;
    if (!rx_en) begin
      rx_nstate = S_IDLE;
    end else begin
      case (rx_state)
        S_IDLE:   if (tick && !rxs) rx_nstate = S_START;
        S_START:
          if (rx_decide && maj) rx_nstate = S_IDLE;
          else if (rx_bit_end)  rx_nstate = S_DATA;
        S_DATA:
          if (rx_bit_end && rx_bcnt == LAST_BIT) rx_nstate = parity_en ? S_PARITY : S_STOP;
        S_PARITY: if (rx_bit_end) rx_nstate = S_STOP;
        S_STOP:
          if (rx_decide) begin
            rx_push   = 1'b1;
            rx_nstate = S_IDLE;
          end
        default:  rx_nstate = S_IDLE;
      endcase
    end
  end

  // The 4-bit tick count wraps 15->0 on its own, so bit boundaries need no reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= S_IDLE;
      rx_tcnt   <= '0;
      rx_bcnt   <= '0;
      rx_smp    <= 3'b111;
      rx_sh     <= '0;
      rx_perr_r <= 1'b0;
    end else begin
      rx_state <= rx_nstate;
      if (rx_state == S_IDLE) begin
        rx_tcnt   <= '0;
        rx_bcnt   <= '0;
        rx_perr_r <= 1'b0;
      end else if (tick) begin
        rx_tcnt <= rx_tcnt + 4'd1;
        if (rx_tcnt >= 4'd7 && rx_tcnt <= 4'd9) rx_smp <= {rx_smp[1:0], rxs};
        if (rx_decide && rx_state == S_DATA)   rx_sh <= {maj, rx_sh[DATA_BITS-1:1]};
        if (rx_decide && rx_state == S_PARITY) rx_perr_r <= maj ^ (^rx_sh) ^ parity_odd;
        if (rx_bit_end && rx_state == S_DATA)  rx_bcnt <= rx_bcnt + 4'd1;
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS+1:0] rx_mem [RX_DEPTH];
  logic [RXA-1:0]       rx_wp, rx_rp;
  logic [RXL-1:0]       rx_cnt;
  logic                 rx_pop, rx_acc, rx_ovf;

  assign rx_full  = (rx_cnt == RXL'(RX_DEPTH));
  assign rx_valid = (rx_cnt != '0);
  assign rx_level = rx_cnt;
  assign rx_pop   = rx_rd_en && rx_valid;
  assign rx_acc   = rx_push && (!rx_full || rx_pop);
  assign rx_ovf   = rx_push && rx_full && !rx_pop;
  assign {rx_perr, rx_ferr, rx_data} = rx_mem[rx_rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RX_DEPTH; i++) rx_mem[i] <= '0;
      rx_wp   <= '0;
      rx_rp   <= '0;
      rx_cnt  <= '0;
      rx_oerr <= 1'b0;
    end else begin
      // Zero-on-pop comes first so a simultaneous push into the same slot (full case) wins.
      if (rx_pop) begin
        rx_mem[rx_rp] <= '0;
        rx_rp         <= rx_rp + RXA'(1);
      end
      if (rx_acc) begin
        rx_mem[rx_wp] <= rx_word;
        rx_wp         <= rx_wp + RXA'(1);
      end
      rx_cnt <= rx_cnt + RXL'(rx_acc) - RXL'(rx_pop);
      if (rx_ovf)                   rx_oerr <= 1'b1;
      else if (oerr_clr || !rx_en)  rx_oerr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_txd, uart_rxd;
  logic        rxd_drv = 1'b1;
  logic        loop = 1'b0;
  logic [11:0] baud_div = '0;
  logic        parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
  logic        tx_en = 1'b0, rx_en = 1'b1;
  logic [7:0]  tx_data = '0;
  logic        tx_wr_en = 1'b0;
  logic        tx_full, tx_empty, tx_busy;
  logic [2:0]  tx_level;
  logic [7:0]  rx_data;
  logic        rx_ferr, rx_perr;
  logic        rx_rd_en = 1'b0;
  logic        rx_valid, rx_full;
  logic [2:0]  rx_level;
  logic        rx_oerr;
  logic        oerr_clr = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int          L = 16;
  logic        exp_oerr = 1'b0;
  logic [9:0]  rxq[$];
  logic [7:0]  txq[$];

  always #5 clk = ~clk;
  assign uart_rxd = loop ? uart_txd : rxd_drv;

  uart_fifo #(.DATA_BITS(8), .TX_DEPTH(4), .RX_DEPTH(4), .DIV_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .UART_TXD(uart_txd), .UART_RXD(uart_rxd),
    .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .tx_en(tx_en), .rx_en(rx_en), .tx_data(tx_data), .tx_wr_en(tx_wr_en),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy), .tx_level(tx_level),
    .rx_data(rx_data), .rx_ferr(rx_ferr), .rx_perr(rx_perr), .rx_rd_en(rx_rd_en),
    .rx_valid(rx_valid), .rx_full(rx_full), .rx_level(rx_level),
    .rx_oerr(rx_oerr), .oerr_clr(oerr_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_div(input int d);
    baud_div = 12'(d);
    L = 16 * (d + 1);
  endtask

  // Expected line bits of one frame, first bit in bit 0.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic pe,
                                             input logic po, input logic s2, output int n);
    logic [15:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    n = 9;
    if (pe) begin b[n] = (^d) ^ po; n++; end
    b[n] = 1'b1; n++;
    if (s2) begin b[n] = 1'b1; n++; end
    return b;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_txd"},      32'(uart_txd), 32'd1);
    check({tag, "_tx_empty"}, 32'(tx_empty), 32'd1);
    check({tag, "_tx_full"},  32'(tx_full),  32'd0);
    check({tag, "_tx_busy"},  32'(tx_busy),  32'd0);
    check({tag, "_tx_level"}, 32'(tx_level), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_full"},  32'(rx_full),  32'd0);
    check({tag, "_rx_level"}, 32'(rx_level), 32'd0);
    check({tag, "_rx_head"},  32'({rx_perr, rx_ferr, rx_data}), 32'd0);
    check({tag, "_rx_oerr"},  32'(rx_oerr),  32'd0);
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data  = d;
    tx_wr_en = 1'b1;
    @(negedge clk);
    tx_wr_en = 1'b0;
  endtask

  task automatic wait_txd_low(output bit ok);
    int t = 0;
    while (uart_txd !== 1'b0 && t < 64 * L) begin @(negedge clk); t++; end
    ok = (uart_txd === 1'b0);
    check("txd_start_seen", 32'(ok), 32'd1);
  endtask

  // Samples each bit in its middle, starting from the falling start edge.
  task automatic capture(input string tag, input logic [7:0] d, input logic pe,
                         input logic po, input logic s2, output logic [15:0] got);
    int n;
    logic [15:0] exp;
    bit ok;
    exp = frame_bits(d, pe, po, s2, n);
    got = '1;
    wait_txd_low(ok);
    if (ok) begin
      repeat (L / 2) @(negedge clk);
      for (int i = 0; i < n; i++) begin
        got[i] = uart_txd;
        if (i < n - 1) repeat (L) @(negedge clk);
      end
    end
    check(tag, 32'(got), 32'(exp));
  endtask

  task automatic drive_bit(input logic b);
    rxd_drv = b;
    repeat (L) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic pe, input logic pbit, input logic stopv);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pe) drive_bit(pbit);
    drive_bit(stopv);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  // Reference for what the receiver should store for a frame put on the line.
  task automatic expect_rx(input logic [7:0] d, input logic pe, input logic pbit, input logic stopv);
    logic perr;
    perr = pe & (pbit ^ ((^d) ^ parity_odd));
    if (rxq.size() < 4) rxq.push_back({perr, ~stopv, d});
    else                exp_oerr = 1'b1;
  endtask

  task automatic wait_rx(input int lvl);
    int t = 0;
    while (int'(rx_level) != lvl && t < 64 * L) begin @(negedge clk); t++; end
    check("rx_wait_level", 32'(rx_level), 32'(lvl));
  endtask

  task automatic pop_rx(input string tag);
    logic [9:0] e;
    e = '0;
    if (rxq.size() > 0) e = rxq.pop_front();
    check(tag, 32'({rx_perr, rx_ferr, rx_data}), 32'(e));
    rx_rd_en = 1'b1;
    @(negedge clk);
    rx_rd_en = 1'b0;
  endtask

  initial begin
    logic [15:0] got, fb, s;
    logic [7:0]  d;
    logic        pb;
    bit          ok, sawlow;
    int          n;

    // reset state
    set_div(0);
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // TX 8N1 exact timing at baud_div=0
    tx_en = 1'b1;
    push_tx(8'h55);
    check("tx_level_after_push", 32'(tx_level), 32'd1);
    check("tx_empty_after_push", 32'(tx_empty), 32'd0);
    wait_txd_low(ok);
    check("tx8n1_busy_start", 32'(tx_busy), 32'd1);
    fb = frame_bits(8'h55, 1'b0, 1'b0, 1'b0, n);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 16; j++) begin
        s[j] = uart_txd;
        @(negedge clk);
      end
      check("tx8n1_bit", 32'(s), 32'({16{fb[i]}}));
    end
    check("tx8n1_busy_end", 32'(tx_busy), 32'd0);
    check("tx8n1_idle_line", 32'(uart_txd), 32'd1);

    // parity loopback, even parity, two stop bits
    set_div(1);
    tx_en = 1'b0; loop = 1'b1; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
    push_tx(8'hA3);
    push_tx(8'h00);
    expect_rx(8'hA3, 1'b1, (^8'hA3) ^ parity_odd, 1'b1);
    expect_rx(8'h00, 1'b1, (^8'h00) ^ parity_odd, 1'b1);
    tx_en = 1'b1;
    capture("lb_frame_a3", 8'hA3, 1'b1, 1'b0, 1'b1, got);
    check("lb_parity_a3", 32'(got[9]), 32'd0);
    capture("lb_frame_00", 8'h00, 1'b1, 1'b0, 1'b1, got);
    check("lb_parity_00", 32'(got[9]), 32'd0);
    wait_rx(2);
    pop_rx("lb_rx_a3");
    pop_rx("lb_rx_00");
    loop = 1'b0; parity_en = 1'b0; stop2 = 1'b0;

    // TX FIFO full: five pushes with the transmitter held off
    tx_en = 1'b0;
    repeat (4 * L) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      push_tx(d);
      if (txq.size() < 4) txq.push_back(d);
    end
    check("txfifo_full", 32'(tx_full), 32'd1);
    check("txfifo_level", 32'(tx_level), 32'd4);
    tx_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = txq.pop_front();
      capture("txfifo_frame", d, 1'b0, 1'b0, 1'b0, got);
    end
    sawlow = 1'b0;
    repeat (3 * L) begin
      @(negedge clk);
      if (uart_txd === 1'b0) sawlow = 1'b1;
    end
    check("txfifo_no_fifth", 32'(sawlow), 32'd0);
    check("txfifo_empty_end", 32'(tx_empty), 32'd1);

    // RX overrun: five frames, no reads
    exp_oerr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      expect_rx(d, 1'b0, 1'b0, 1'b1);
      drive_frame(d, 1'b0, 1'b0, 1'b1);
    end
    check("ovr_full", 32'(rx_full), 32'd1);
    check("ovr_level", 32'(rx_level), 32'd4);
    check("ovr_oerr", 32'(rx_oerr), 32'(exp_oerr));
    for (int i = 0; i < 4; i++) pop_rx("ovr_entry");
    oerr_clr = 1'b1;
    @(negedge clk);
    oerr_clr = 1'b0;
    check("ovr_valid_after", 32'(rx_valid), 32'd0);
    check("ovr_oerr_cleared", 32'(rx_oerr), 32'd0);
    check("ovr_head_zero", 32'({rx_perr, rx_ferr, rx_data}), 32'd0);
    rx_rd_en = 1'b1;
    @(negedge clk);
    rx_rd_en = 1'b0;
    check("empty_pop_level", 32'(rx_level), 32'd0);

    // framing error, glitch, parity errors
    d = 8'($urandom);
    expect_rx(d, 1'b0, 1'b0, 1'b0);
    drive_frame(d, 1'b0, 1'b0, 1'b0);
    wait_rx(1);
    pop_rx("rx_ferr_entry");
    rxd_drv = 1'b0;
    repeat (3 * (L / 16)) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (2 * L) @(negedge clk);
    check("glitch_level", 32'(rx_level), 32'd0);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    parity_en = 1'b1; parity_odd = 1'b1;
    d = 8'($urandom);
    pb = ~((^d) ^ parity_odd);
    expect_rx(d, 1'b1, pb, 1'b1);
    drive_frame(d, 1'b1, pb, 1'b1);
    wait_rx(1);
    pop_rx("rx_perr_bad");
    d = 8'($urandom);
    pb = (^d) ^ parity_odd;
    expect_rx(d, 1'b1, pb, 1'b1);
    drive_frame(d, 1'b1, pb, 1'b1);
    wait_rx(1);
    pop_rx("rx_perr_good");
    parity_en = 1'b0; parity_odd = 1'b0;

    // reset in the middle of a TX frame and an RX frame
    tx_en = 1'b1;
    push_tx(8'h96);
    push_tx(8'h11);
    wait_txd_low(ok);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("mid_tx_busy", 32'(tx_busy), 32'd1);
    check("mid_tx_level", 32'(tx_level), 32'd1);
    rst_n = 1'b0;
    rxd_drv = 1'b1;
    #1;
    check_reset("rst_mid");
    rxq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_tx(8'h3C);
    capture("post_rst_3c", 8'h3C, 1'b0, 1'b0, 1'b0, got);
    d = 8'($urandom);
    expect_rx(d, 1'b0, 1'b0, 1'b1);
    drive_frame(d, 1'b0, 1'b0, 1'b1);
    wait_rx(1);
    pop_rx("post_rst_rx");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
